// File: rtl/qpp_interleaver.sv
// qpp_interleaver
//   QPP turbo internal interleaver for the NB-IoT uplink turbo encoder.
//   Latches one K-bit code block and produces c'(i) = c(pi(i)) with
//   pi(i) = (F1*i + F2*i^2) mod K, one index per clock. pi is generated
//   recursively (pi += g, g += 2*F2), so no multipliers are needed.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle request; accepted only when idle
//   din        in   [0:K-1] code block, din[0] is the first bit
//   dout       out  [0:K-1] interleaved block, valid when done pulses
//   ser_bit    out  serial interleaved bit c'(ser_idx)
//   ser_valid  out  ser_bit/ser_idx valid
//   ser_idx    out  [AW-1:0] output index of ser_bit
//   busy       out  high from accept until done
//   done       out  one-cycle pulse, dout complete and stable
module qpp_interleaver #(
   parameter int K  = 40,
   parameter int F1 = 3,
   parameter int F2 = 10,
   localparam int AW = $clog2(K)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [0:K-1]  din,
   output logic [0:K-1]  dout,
   output logic          ser_bit,
   output logic          ser_valid,
   output logic [AW-1:0] ser_idx,
   output logic          busy,
   output logic          done
);

   localparam logic [AW:0]   LP_K    = (AW+1)'(K);
   localparam logic [AW-1:0] LP_G0   = AW'((F1 + F2) % K);
   localparam logic [AW-1:0] LP_DG   = AW'((2 * F2) % K);
   localparam logic [AW-1:0] LP_LAST = AW'(K - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIN
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          w_accept;
   logic          w_emit;
   logic          w_finish;

   logic [0:K-1]  r_din;
   logic [AW-1:0] r_i;
   logic [AW-1:0] r_pi;
   logic [AW-1:0] r_g;

   logic [AW:0]   w_pi_sum;
   logic [AW:0]   w_g_sum;
   logic [AW-1:0] w_pi_nxt;
   logic [AW-1:0] w_g_nxt;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and per-cycle control strobes
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_emit      = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && !busy) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            w_emit = 1'b1;
            if (r_i == LP_LAST) begin
               w_state_nxt = S_FIN;
            end
         end
         S_FIN: begin
            w_finish    = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Both operands are < K, so each sum is < 2K and one conditional
   // subtract of K gives the exact modulo.
   always_comb begin
      w_pi_sum = {1'b0, r_pi} + {1'b0, r_g};
      w_g_sum  = {1'b0, r_g} + {1'b0, LP_DG};
      w_pi_nxt = (w_pi_sum >= LP_K) ? AW'(w_pi_sum - LP_K) : AW'(w_pi_sum);
      w_g_nxt  = (w_g_sum  >= LP_K) ? AW'(w_g_sum  - LP_K) : AW'(w_g_sum);
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_din     <= '0;
         r_i       <= '0;
         r_pi      <= '0;
         r_g       <= '0;
         dout      <= '0;
         ser_bit   <= 1'b0;
         ser_valid <= 1'b0;
         ser_idx   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= w_finish;
         if (w_accept) begin
            r_din <= din;
            r_i   <= '0;
            r_pi  <= '0;
            r_g   <= LP_G0;
            busy  <= 1'b1;
            dout  <= '0;
         end
         if (w_emit) begin
            dout[r_i] <= r_din[r_pi];
            ser_bit   <= r_din[r_pi];
            ser_idx   <= r_i;
            ser_valid <= 1'b1;
            r_pi      <= w_pi_nxt;
            r_g       <= w_g_nxt;
            r_i       <= r_i + 1'b1;
         end
         if (w_finish) begin
            busy      <= 1'b0;
            ser_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_qpp_interleaver.sv
// tb_qpp_interleaver
//   Directed self-checking bench for qpp_interleaver with K=40, F1=3, F2=10.
//   Expected permutation is taken from the closed form (3i + 10i^2) mod 40.
module tb_qpp_interleaver;

   localparam int K  = 40;
   localparam int AW = 6;

   logic          clk;
   logic          rst;
   logic          start;
   logic [0:K-1]  din;
   logic [0:K-1]  dout;
   logic          ser_bit;
   logic          ser_valid;
   logic [AW-1:0] ser_idx;
   logic          busy;
   logic          done;

   int n_checks;
   int n_errors;

   qpp_interleaver #(.K(K), .F1(3), .F2(10)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .din       (din),
      .dout      (dout),
      .ser_bit   (ser_bit),
      .ser_valid (ser_valid),
      .ser_idx   (ser_idx),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pi_m(input int i);
      return (3 * i + 10 * i * i) % K;
   endfunction

   // Starts a block from a point just after a rising edge and follows it to
   // the done cycle, where it returns. A non-zero inj re-pulses start (with
   // din inverted) at that cycle while the block is running.
   task automatic run_block(input logic [0:K-1] d, input int inj,
                            output int hit, output int n_ones);
      logic [0:K-1] e;
      for (int i = 0; i < K; i++) e[i] = d[pi_m(i)];
      hit    = -1;
      n_ones = 0;
      din    = d;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("acc_busy", 64'(busy), 64'd1);
      chk("acc_dout", 64'(dout), 64'd0);
      chk("acc_done", 64'(done), 64'd0);
      chk("acc_sval", 64'(ser_valid), 64'd0);
      for (int c = 1; c <= K + 1; c++) begin
         @(posedge clk); #1;
         if (c <= K) begin
            chk($sformatf("sval[%0d]", c - 1), 64'(ser_valid), 64'd1);
            chk($sformatf("sidx[%0d]", c - 1), 64'(ser_idx), 64'(c - 1));
            chk($sformatf("sbit[%0d]", c - 1), 64'(ser_bit), 64'(e[c-1]));
            chk($sformatf("done_early[%0d]", c - 1), 64'(done), 64'd0);
            chk($sformatf("busy_run[%0d]", c - 1), 64'(busy), 64'd1);
            if (ser_valid && ser_bit) begin
               if (n_ones == 0) hit = int'(ser_idx);
               n_ones++;
            end
         end else begin
            chk("fin_done", 64'(done), 64'd1);
            chk("fin_busy", 64'(busy), 64'd0);
            chk("fin_sval", 64'(ser_valid), 64'd0);
            chk("fin_dout", 64'(dout), 64'(e));
         end
         if (inj > 0 && c == inj) begin
            start = 1'b1;
            din   = ~d;
         end else begin
            start = 1'b0;
         end
      end
   endtask

   // One cycle after the done cycle: pulse is gone, dout still held.
   task automatic post_idle(input logic [0:K-1] e);
      @(posedge clk); #1;
      chk("post_done", 64'(done), 64'd0);
      chk("post_busy", 64'(busy), 64'd0);
      chk("post_dout", 64'(dout), 64'(e));
   endtask

   function automatic logic [0:K-1] expect_of(input logic [0:K-1] d);
      logic [0:K-1] e;
      for (int i = 0; i < K; i++) e[i] = d[pi_m(i)];
      return e;
   endfunction

   function automatic logic [0:K-1] onehot(input int p);
      logic [0:K-1] v;
      v    = '0;
      v[p] = 1'b1;
      return v;
   endfunction

   typedef struct { int p; int i; } trace_t;

   initial begin
      int            hit;
      int            n_ones;
      int            n_done;
      int            inv;
      logic [0:K-1]  d;
      logic [0:K-1]  d2;
      trace_t        tr[4];

      n_checks = 0;
      n_errors = 0;
      rst   = 1'b1;
      start = 1'b0;
      din   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dout", 64'(dout), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_sval", 64'(ser_valid), 64'd0);
      chk("rst_sidx", 64'(ser_idx), 64'd0);
      chk("rst_sbit", 64'(ser_bit), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // T1: single one at din[13] lands at output index 1
      run_block(onehot(13), 0, hit, n_ones);
      chk("t1_dout", 64'(dout), 64'h40_0000_0000);
      chk("t1_hit", 64'(hit), 64'd1);
      chk("t1_ones", 64'(n_ones), 64'd1);
      post_idle(onehot(1));

      // T2: hand-computed trace points pi(1..3)=13,6,19 and pi(39)=7
      tr[0] = '{13, 1};
      tr[1] = '{6, 2};
      tr[2] = '{19, 3};
      tr[3] = '{7, 39};
      for (int k = 0; k < 4; k++) begin
         run_block(onehot(tr[k].p), 0, hit, n_ones);
         chk($sformatf("t2_hit_p%0d", tr[k].p), 64'(hit), 64'(tr[k].i));
         post_idle(onehot(tr[k].i));
      end

      // T2: every source bit appears exactly once, at its inverse index
      for (int p = 0; p < K; p++) begin
         inv = -1;
         for (int i = 0; i < K; i++) if (pi_m(i) == p) inv = i;
         run_block(onehot(p), 0, hit, n_ones);
         chk($sformatf("perm_hit_p%0d", p), 64'(hit), 64'(inv));
         chk($sformatf("perm_ones_p%0d", p), 64'(n_ones), 64'd1);
      end
      post_idle(expect_of(onehot(K - 1)));

      // T3: random block, then a second block started in the done cycle
      d  = {$urandom(), 8'($urandom())};
      d2 = {$urandom(), 8'($urandom())};
      run_block(d, 0, hit, n_ones);
      run_block(d2, 0, hit, n_ones);
      post_idle(expect_of(d2));

      // T4: start re-pulsed while busy, din changed mid-block
      d = {$urandom(), 8'($urandom())};
      run_block(d, 5, hit, n_ones);
      post_idle(expect_of(d));
      repeat (3) begin
         @(posedge clk); #1;
         chk("t4_no_restart", 64'(busy), 64'd0);
      end

      // T5: reset mid-block aborts it
      d     = {$urandom(), 8'($urandom())};
      din   = d;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_sval", 64'(ser_valid), 64'd0);
      chk("t5_dout", 64'(dout), 64'd0);
      chk("t5_done", 64'(done), 64'd0);
      n_done = 0;
      repeat (45) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      chk("t5_no_done", 64'(n_done), 64'd0);
      d = {$urandom(), 8'($urandom())};
      run_block(d, 0, hit, n_ones);
      post_idle(expect_of(d));

      // T6: all ones / all zeros pass through unchanged
      run_block('1, 0, hit, n_ones);
      chk("t6_ones", 64'(dout), 64'hFF_FFFF_FFFF);
      chk("t6_ones_cnt", 64'(n_ones), 64'd40);
      post_idle('1);
      run_block('0, 0, hit, n_ones);
      chk("t6_zeros", 64'(dout), 64'd0);
      chk("t6_zeros_cnt", 64'(n_ones), 64'd0);
      post_idle('0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
